bcd_xs3_codec: RTL and testbench

Parametrised, digit-serial, bidirectional BCD ↔ Excess-3 converter for multi-digit words.

- Accepts a packed word of `DIGITS` nibbles over a valid/ready handshake and converts one digit per clock, least-significant nibble first.
- Flags every digit that is illegal for the selected code.
- Holds the result until the consumer takes it.
- Sits between numeric front-end logic and display/arithmetic back-ends that need either code.

---
 rtl/bcd_xs3_codec.sv | 120 ++++++++++++
 tb/tb_bcd_xs3_codec.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_codec.sv
// bcd_xs3_codec: digit-serial BCD <-> Excess-3 converter for a packed word.
// A word is accepted in IDLE, converted one nibble per clock LSB-first in CONV,
// and held in DONE until the consumer takes it. Illegal digits produce 4'hF
// and set their bit in the error mask.
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   CONV  | converting digit idx, one per clock
//   DONE  | result held, out_valid high until out_ready
module bcd_xs3_codec #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [4*DIGITS-1:0]  data_reg;
    logic                 mode_reg;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           digit;
    logic [3:0]           result;
    logic                 legal;
    logic                 last_digit;

    assign last_digit = (idx == IDX_W'(DIGITS - 1));

    // Convert the currently indexed digit of the captured word.
    always_comb begin
        digit  = data_reg[4*idx +: 4];
        legal  = 1'b0;
        result = 4'hF;
        if (!mode_reg) begin
            legal  = (digit <= 4'd9);
            result = digit + 4'd3;
        end else begin
            legal  = (digit >= 4'd3) && (digit <= 4'd12);
            result = digit - 4'd3;
        end
        if (!legal) begin
            result = 4'hF;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CONV;
            CONV: if (last_digit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture on accept, then write one result nibble and mask bit per clock.
    // idx parks on the last digit; it is cleared again at the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg     <= '0;
            mode_reg     <= 1'b0;
            idx          <= '0;
            out_data     <= '0;
            out_err_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_data;
                        mode_reg     <= in_mode;
                        out_err_mask <= '0;
                        idx          <= '0;
                    end
                end
                CONV: begin
                    out_data[4*idx +: 4] <= result;
                    out_err_mask[idx]    <= ~legal;
                    if (!last_digit) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_err   = |out_err_mask;

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Directed bench for bcd_xs3_codec: a 4-digit instance and a 1-digit instance.
module tb_bcd_xs3_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_err_mask;
    logic        out_err;
    logic        busy;

    logic        in_valid_1 = 1'b0;
    logic        in_ready_1;
    logic        in_mode_1 = 1'b0;
    logic [3:0]  in_data_1 = '0;
    logic        out_valid_1;
    logic        out_ready_1 = 1'b0;
    logic [3:0]  out_data_1;
    logic [0:0]  out_err_mask_1;
    logic        out_err_1;
    logic        busy_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_xs3_codec #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err_mask(out_err_mask), .out_err(out_err), .busy(busy)
    );

    bcd_xs3_codec #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_mode(in_mode_1), .in_data(in_data_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
        .out_err_mask(out_err_mask_1), .out_err(out_err_1), .busy(busy_1)
    );

    // Present one word for a single accept edge, then scramble the inputs and
    // count rising edges until out_valid (capped so the bench cannot hang).
    task automatic send_word(input logic [15:0] d, input logic m, output int lat);
        @(negedge clk);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_mode  = ~m;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_word();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 16'h0 || out_err_mask !== 4'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b busy=%b ready=%b data=%h mask=%b err=%b, required 0 0 1 0000 0000 0",
                     out_valid, busy, in_ready, out_data, out_err_mask, out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_basic();
        int lat;
        send_word(16'h1234, 1'b0, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL mode0_latency: got %0d edges, required 4", lat);
        end
        n_tests++;
        if (out_data !== 16'h4567 || out_err_mask !== 4'b0000 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mode0_1234: data=%h mask=%b err=%b, required 4567 0000 0", out_data, out_err_mask, out_err);
        end
        take_word();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h4567) begin
            n_fail++;
            $display("FAIL release: valid=%b ready=%b data=%h, required 0 1 4567", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_mode1_basic();
        int lat;
        send_word(16'hC333, 1'b1, lat);
        n_tests++;
        if (lat !== 4 || out_data !== 16'h9000 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mode1_C333: lat=%0d data=%h err=%b, required 4 9000 0", lat, out_data, out_err);
        end
        take_word();
    endtask

    task automatic test_errors();
        int lat;
        send_word(16'h9A05, 1'b0, lat);
        n_tests++;
        if (out_data !== 16'hCF38 || out_err_mask !== 4'b0100 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_mode0_9A05: data=%h mask=%b err=%b, required CF38 0100 1", out_data, out_err_mask, out_err);
        end
        take_word();
        send_word(16'h0F33, 1'b1, lat);
        n_tests++;
        if (out_data !== 16'hFF00 || out_err_mask !== 4'b1100 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_mode1_0F33: data=%h mask=%b err=%b, required FF00 1100 1", out_data, out_err_mask, out_err);
        end
        take_word();
    endtask

    task automatic test_backpressure();
        int lat;
        send_word(16'h1234, 1'b0, lat);
        @(negedge clk);
        in_data  = 16'h0099;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h4567 || out_err_mask !== 4'b0000) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b data=%h mask=%b, required 1 0 4567 0000",
                         i, out_valid, in_ready, out_data, out_err_mask);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_accept: busy=%b ready=%b, required 1 0", busy, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_tests++;
        if (lat !== 4 || out_data !== 16'h33CC || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_next_word: lat=%0d data=%h err=%b, required 4 33CC 0", lat, out_data, out_err);
        end
        take_word();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_data  = 16'h1234;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b busy=%b ready=%b data=%h, required 0 0 1 0000",
                     out_valid, busy, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(16'h0099, 1'b0, lat);
        n_tests++;
        if (lat !== 4 || out_data !== 16'h33CC || out_err_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_reset_0099: lat=%0d data=%h mask=%b, required 4 33CC 0000", lat, out_data, out_err_mask);
        end
        take_word();
    endtask

    task automatic test_digits1();
        @(negedge clk);
        in_data_1  = 4'h9;
        in_mode_1  = 1'b0;
        in_valid_1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid_1 = 1'b0;
        in_data_1  = 4'h0;
        n_tests++;
        if (busy_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_conv: busy=%b valid=%b, required 1 0", busy_1, out_valid_1);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid_1 !== 1'b1 || out_data_1 !== 4'hC || out_err_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_mode0_9: valid=%b data=%h err=%b, required 1 C 0", out_valid_1, out_data_1, out_err_1);
        end
        @(negedge clk);
        out_ready_1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready_1 = 1'b0;
        @(negedge clk);
        in_data_1  = 4'h2;
        in_mode_1  = 1'b1;
        in_valid_1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid_1 = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid_1 !== 1'b1 || out_data_1 !== 4'hF || out_err_1 !== 1'b1 || out_err_mask_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_mode1_2: valid=%b data=%h err=%b mask=%b, required 1 F 1 1",
                     out_valid_1, out_data_1, out_err_1, out_err_mask_1);
        end
        @(negedge clk);
        out_ready_1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready_1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode1_basic();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_digits1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
